// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: addressing-mode codes, immediate field
// layout and the immediate-encoder FSM states.
package arm_pkg;

  localparam int DATA_W = 32;
  localparam int ROT_W  = 4;

  typedef enum logic [1:0] {
    AM_ROT_IMM = 2'b00,
    AM_REG     = 2'b01,
    AM_ZEXT    = 2'b10,
    AM_SHIFT   = 2'b11
  } am_e;

  localparam int IMM_ROT_MSB = 11;
  localparam int IMM_ROT_LSB = 8;
  localparam int IMM8_MSB    = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_e;

endpackage

// File: rtl/arm_imm_encoder_if.sv
// Request/response bus of the rotate-immediate encoder: value in, {encodable, imm12} out,
// each direction with its own valid/ready pair.
interface arm_imm_encoder_if import arm_pkg::*; ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] value;
  logic              out_valid;
  logic              out_ready;
  logic              encodable;
  logic [11:0]       imm12;

  modport master (
    output in_valid, value, out_ready,
    input  in_ready, out_valid, encodable, imm12
  );

  modport slave (
    input  in_valid, value, out_ready,
    output in_ready, out_valid, encodable, imm12
  );

endinterface

// File: rtl/arm_rotl2.sv
// Combinational left-rotate by an even amount (2*rot, modulo DATA_W) with a flag
// that reports whether the rotated word fits in the low 8 bits.
module arm_rotl2 #(
  parameter int DATA_W = 32,
  parameter int ROT_W  = 4
) (
  input  logic [DATA_W-1:0] value,
  input  logic [ROT_W-1:0]  rot,
  output logic [DATA_W-1:0] cand,
  output logic              fits8
);

  logic [ROT_W:0]      amt;
  logic [2*DATA_W-1:0] dbl;

  // Shifting a doubled word leaves value ROL amt in the upper half.
  assign amt   = {rot, 1'b0};
  assign dbl   = {value, value} << amt;
  assign cand  = dbl[2*DATA_W-1:DATA_W];
  assign fits8 = ~|cand[DATA_W-1:8];

endmodule

// File: rtl/arm_imm_encoder.sv
// Iterative ARM rotate-immediate encoder: tries one rotation per clock, smallest rot wins.
// Define ARM_IMM_FASTPATH_EN to skip the search for values that already fit in 8 bits.
module arm_imm_encoder import arm_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  arm_imm_encoder_if.slave   bus
);

  state_e            state, state_nxt;
  logic [DATA_W-1:0] value_q, value_nxt;
  logic [ROT_W-1:0]  rot_q, rot_nxt;
  logic              encodable_q, encodable_nxt;
  logic [11:0]       imm12_q, imm12_nxt;

  logic [DATA_W-1:0] cand;
  logic              fits8;
  logic              unused_cand_hi;

  arm_rotl2 #(.DATA_W(DATA_W), .ROT_W(ROT_W)) u_rotl2 (
    .value (value_q),
    .rot   (rot_q),
    .cand  (cand),
    .fits8 (fits8)
  );

  assign unused_cand_hi = ^cand[DATA_W-1:8];

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt     = state;
    value_nxt     = value_q;
    rot_nxt       = rot_q;
    encodable_nxt = encodable_q;
    imm12_nxt     = imm12_q;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          value_nxt = bus.value;
          rot_nxt   = '0;
          state_nxt = S_SEARCH;
`ifdef ARM_IMM_FASTPATH_EN
          if (~|bus.value[DATA_W-1:8]) begin
            encodable_nxt = 1'b1;
            imm12_nxt     = {4'h0, bus.value[IMM8_MSB:0]};
            state_nxt     = S_DONE;
          end
`else
`endif
        end
      end
      S_SEARCH: begin
        if (fits8) begin
          encodable_nxt                        = 1'b1;
          imm12_nxt[IMM_ROT_MSB:IMM_ROT_LSB]   = rot_q;
          imm12_nxt[IMM8_MSB:0]                = cand[IMM8_MSB:0];
          state_nxt                            = S_DONE;
        end else if (rot_q == '1) begin
          encodable_nxt = 1'b0;
          imm12_nxt     = '0;
          state_nxt     = S_DONE;
        end else begin
          rot_nxt = rot_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the latched operand is reset too; it is cheap here and keeps the
    // rotator input defined straight out of reset.
    if (reset) begin
      state       <= S_IDLE;
      value_q     <= '0;
      rot_q       <= '0;
      encodable_q <= 1'b0;
      imm12_q     <= '0;
    end else begin
      state       <= state_nxt;
      value_q     <= value_nxt;
      rot_q       <= rot_nxt;
      encodable_q <= encodable_nxt;
      imm12_q     <= imm12_nxt;
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.encodable = encodable_q;
  assign bus.imm12     = imm12_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Self-checking bench for arm_imm_encoder: directed cases, hold/reset cases and a random
// sweep against a brute-force model; works with or without ARM_IMM_FASTPATH_EN.
module tb_arm_imm_encoder;
  import arm_pkg::*;

  typedef struct {
    logic [31:0] value;
    logic        enc;
    logic [11:0] imm;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  arm_imm_encoder_if bus ();

  arm_imm_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rol32(logic [31:0] x, int n);
    return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
  endfunction

  function automatic logic [31:0] ror32(logic [31:0] x, int n);
    return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
  endfunction

  // Brute force: a rotation wins when rotating its low byte back reproduces value exactly.
  function automatic exp_t model(logic [31:0] v);
    exp_t        e;
    logic [31:0] c;
    logic [7:0]  i8;
    logic [3:0]  r4;
    e.value = v;
    e.enc   = 1'b0;
    e.imm   = 12'h000;
    e.lat   = 16;
    for (int r = 15; r >= 0; r--) begin
      c  = rol32(v, 2 * r);
      i8 = c[7:0];
      if (ror32({24'h0, i8}, 2 * r) == v) begin
        r4    = r[3:0];
        e.enc = 1'b1;
        e.imm = {r4, i8};
        e.lat = r + 1;
      end
    end
`ifdef ARM_IMM_FASTPATH_EN
    if (v[31:8] == 24'h0) e.lat = 0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one value, measure latency, compare against the scoreboard head,
  // then hold out_ready low for 'hold' cycles before taking the result.
  task automatic do_txn(input logic [31:0] v, input int hold);
    exp_t        e;
    int          lat;
    int          wait_n;
    logic [11:0] imm_seen;
    logic [31:0] back;
    logic [7:0]  i8;
    wait_n = 0;
    while (!bus.in_ready && wait_n < 40) begin
      wait_n++;
      @(negedge clk);
    end
    check("in_ready_before_accept", {31'h0, bus.in_ready}, 32'h1);
    bus.in_valid = 1'b1;
    bus.value    = v;
    sb.push_back(model(v));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.value    = $urandom;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check("out_valid_timeout", {31'h0, bus.out_valid}, 32'h1);
    check("latency", lat, e.lat);
    check("encodable", {31'h0, bus.encodable}, {31'h0, e.enc});
    check("imm12", {20'h0, bus.imm12}, {20'h0, e.imm});
    if (bus.encodable) begin
      i8   = bus.imm12[7:0];
      back = ror32({24'h0, i8}, 2 * int'(bus.imm12[11:8]));
      check("imm_decodes_back", back, e.value);
    end
    imm_seen = bus.imm12;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = h[0];
      bus.value    = $urandom;
      @(negedge clk);
      check("hold_out_valid", {31'h0, bus.out_valid}, 32'h1);
      check("hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
      check("hold_imm12", {20'h0, bus.imm12}, {20'h0, imm_seen});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("release_in_ready", {31'h0, bus.in_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  i8;
    int          r;
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.value     = 32'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_encodable", {31'h0, bus.encodable}, 32'h0);
    check("rst_imm12", {20'h0, bus.imm12}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    do_txn(32'h0000_00FF, 0);
    do_txn(32'hC000_0006, 0);
    do_txn(32'hFF00_0000, 0);
    do_txn(32'h0000_0101, 0);
    do_txn(32'hC000_0006, 5);
    do_txn(32'h0000_0000, 0);

    // Reset during the third SEARCH cycle of an unencodable value.
    bus.in_valid = 1'b1;
    bus.value    = 32'h0000_0101;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midsearch_out_valid", {31'h0, bus.out_valid}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("midreset_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("midreset_imm12", {20'h0, bus.imm12}, 32'h0);
    check("midreset_encodable", {31'h0, bus.encodable}, 32'h0);
    do_txn(32'h0000_03FC, 0);
    check("expect_3fc_model", {20'h0, model(32'h0000_03FC).imm}, 32'hFFF);

    // Reset while a result waits in DONE discards it.
    bus.in_valid = 1'b1;
    bus.value    = 32'h0000_0012;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("done_before_reset", {31'h0, bus.out_valid}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("done_reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("done_reset_in_ready", {31'h0, bus.in_ready}, 32'h1);

    for (int k = 0; k < 48; k++) begin
      case (k % 3)
        0: v = $urandom;
        1: begin
          i8 = 8'($urandom);
          r  = int'($urandom_range(15, 0));
          v  = ror32({24'h0, i8}, 2 * r);
        end
        default: v = {24'h0, 8'($urandom)} << $urandom_range(24, 0);
      endcase
      do_txn(v, k % 4);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
